data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Multi-cycle data memory for the MEM stage of the pipelined CPU. It accepts a single word read or write request from the pipeline, which acts as the initiator. It completes the request after a fixed `DELAY`, then returns read data with a one-cycle valid pulse. While a request is outstanding it drives `mem_stall`, which the pipeline control combines with the load-use stall to hold PC, IF/ID, ID/EX and EX/MEM.

## Interface
- `MEM_DEPTH`, 16384: number of 32-bit words; must be a power of two.
- `DELAY`, 4: number of cycles from acceptance to response; must be at least 1.

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears control state.
- `is_input_valid` input 1: a request is present this cycle.
- `addr` input 32: byte address. Word index is `addr[log2(MEM_DEPTH)+1:2]`. `addr[1:0]` and the upper bits are ignored, so addresses wrap modulo `MEM_DEPTH`.
- `mem_read` input 1: the request is a load.
- `mem_write` input 1: the request is a store.
- `din` input 32: store data.
- `is_ready` output 1: the block can accept a request this cycle.
- `is_output_valid` output 1: the response is complete this cycle.
- `dout` output 32: load data; meaningful only while `is_output_valid` is high on a read.
- `mem_stall` output 1: the pipeline must hold this cycle.

## Operation
- States: IDLE, BUSY, DONE. On reset the block is in IDLE with `cnt` = 0.
- A request is valid when `is_input_valid` is high and exactly one of `mem_read`/`mem_write` is high.
  - Both or neither high: the request is not accepted. The block stays in IDLE with no stall and no response.
- IDLE:
  - `is_ready` is 1.
  - A valid request is accepted at the clock edge. At that edge the block latches `addr`, `din` and the operation, and loads `cnt` with `DELAY-1`.
  - Next state is BUSY if `DELAY` > 1, otherwise DONE.
- BUSY:
  - Inputs are ignored; the latched values are used.
  - `cnt` decrements each cycle.
  - When `cnt` == 1, the next state is DONE. At that same edge the block commits the write to the array, or registers the array word into `dout` for a read.
  - When `DELAY` == 1, the commit or capture happens at the accepting edge instead.
- DONE:
  - Lasts exactly one cycle; `is_output_valid` is 1.
  - Reads: `dout` holds the data.
  - Writes: `is_output_valid` is also 1, as a completion acknowledge, and `dout` is 0.
  - Next state is IDLE unconditionally. No request is accepted in DONE.
- `mem_stall` is combinational. It is 1 when the state is BUSY, or when the state is IDLE and a valid request is present. It is 0 in DONE, so the pipeline advances at the DONE edge and captures `dout`.
- `is_ready` is 1 only in IDLE.
- Array contents are not affected by reset. Only state, `cnt`, `dout` and the latched request are cleared.
- Reset mid-request:
  - The block returns to IDLE immediately.
  - A pending write is discarded and never committed.
  - `is_output_valid` and `dout` go to 0 at once.

## Timing
- Reset values of the outputs: `is_ready` = 1, `is_output_valid` = 0, `dout` = 0, `mem_stall` = 0.
- A request presented in cycle N is accepted at the end of cycle N.
  - `mem_stall` is 1 in cycles N through N+DELAY-1.
  - DONE, with the `is_output_valid` pulse, is cycle N+DELAY.
  - `is_ready` returns to 1 in cycle N+DELAY+1.
- Throughput: one request per DELAY+1 cycles. Back-to-back requests are accepted no sooner than the cycle after DONE.
- A read that follows a write to the same word observes the new data, because the write commits before the write's DONE cycle.
- `dout` is registered. It changes only on entry to DONE (to the read data, or to 0 for a write) and on exit from DONE or on reset (to 0).

## Test plan
- Reset: assert `reset` asynchronously between clock edges. Required: `is_ready` = 1, `is_output_valid` = 0, `dout` = 0 and `mem_stall` = 0 before the next edge.
- DELAY = 4, write 0xDEADBEEF to 0x100 with the request in cycle 0. Required:
  - `mem_stall` is 1 in cycles 0–3.
  - `is_output_valid` is 1 in cycle 4 only.
  - `is_ready` is 1 in cycle 5.
  - A following read of 0x100 returns `dout` = 0xDEADBEEF with `is_output_valid` 4 cycles after its acceptance.
- Input change while BUSY: during a read of 0x100, drive `addr` = 0x200, `din` = 0x1 and `mem_write` = 1 in cycle 2. Required:
  - `dout` = 0xDEADBEEF.
  - A later read of 0x200 returns its prior value, showing the mid-request write had no effect.
- Reset mid-write: write 0 to 0x104 and let it complete. Then start a write of 0x12345678 to 0x104 and assert `reset` in cycle 2. Required:
  - The block returns to IDLE with no `is_output_valid` pulse.
  - A read of 0x104 returns 0x00000000.
- Illegal and absent requests: `is_input_valid` = 1 with both `mem_read` and `mem_write` high, and then with both low. Required: `is_ready` stays 1, `mem_stall` stays 0, and no pulse occurs over 8 cycles.
- DELAY = 1 instance: read 0x100 + 4·MEM_DEPTH after writing 0xCAFEF00D to 0x100. Required:
  - `mem_stall` is 1 for 1 cycle only.
  - `is_output_valid` is 1 in the next cycle with `dout` = 0xCAFEF00D, confirming address wrap.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle word memory for the MEM stage. Holds the pipeline
// with mem_stall while a request is in flight, then pulses is_output_valid for one cycle.
module data_mem_responder #(
  parameter int MEM_DEPTH = 16384,
  parameter int DELAY     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        is_input_valid,
  input  logic [31:0] addr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] din,
  output logic        is_ready,
  output logic        is_output_valid,
  output logic [31:0] dout,
  output logic        mem_stall
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = (DELAY > 1) ? $clog2(DELAY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   din_q;
  logic          wr_q;
  logic [31:0]   dout_q;

  logic [31:0]   memArray [MEM_DEPTH];

  logic          reqValid;
  logic [AW-1:0] reqIdx;
  logic          commitEn;
  logic          commitWr;
  logic [AW-1:0] commitIdx;
  logic [31:0]   commitData;
  logic          unusedAddrBits;

  assign reqValid       = is_input_valid && (mem_read ^ mem_write);
  assign reqIdx         = addr[AW+1:2];
  assign unusedAddrBits = ^{addr[31:AW+2], addr[1:0]};

  // A single-cycle memory commits straight from the live request on the accepting edge;
  // otherwise the latched request commits on the edge that enters DONE.
  always_comb begin
    commitEn   = 1'b0;
    commitWr   = wr_q;
    commitIdx  = addr_q;
    commitData = din_q;
    if (state_q == IDLE) begin
      commitEn   = (DELAY == 1) && reqValid;
      commitWr   = mem_write;
      commitIdx  = reqIdx;
      commitData = din;
    end else if (state_q == BUSY) begin
      commitEn = (cnt_q == CW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (commitEn && commitWr && !reset) begin
      memArray[commitIdx] <= commitData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      wr_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (reqValid) begin
            addr_q  <= reqIdx;
            din_q   <= din;
            wr_q    <= mem_write;
            cnt_q   <= CW'(DELAY - 1);
            state_q <= (DELAY > 1) ? BUSY : DONE;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          dout_q  <= '0;
        end
        default: state_q <= IDLE;
      endcase
      // Writes acknowledge with zero data so dout only ever carries load results.
      if (commitEn) begin
        dout_q <= commitWr ? 32'h0 : memArray[commitIdx];
      end
    end
  end

  assign is_ready        = (state_q == IDLE);
  assign is_output_valid = (state_q == DONE);
  assign dout            = dout_q;
  assign mem_stall       = (state_q == BUSY) || ((state_q == IDLE) && reqValid);

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a DELAY=4 and a DELAY=1 instance checked every cycle
// against a cycle-timeline model, plus directed literal expectations.
module tb_data_mem_responder;

  localparam int DEPTH = 16384;
  localparam int D0    = 4;
  localparam int D1    = 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  logic        iv    [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] ad    [2];
  logic [31:0] di    [2];
  logic        rdy   [2];
  logic        ov    [2];
  logic [31:0] dout  [2];
  logic        stall [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit started = 1'b0;

  // Model: a request accepted at the end of cycle acc is busy until acc+D-1 and done in acc+D.
  bit          pend  [2];
  int          acc   [2];
  bit          pRead [2];
  int          pIdx  [2];
  logic [31:0] pData [2];
  logic [31:0] modelMem [int];

  data_mem_responder #(.MEM_DEPTH(DEPTH), .DELAY(D0)) dut4 (
    .clk(clk), .reset(reset), .is_input_valid(iv[0]), .addr(ad[0]),
    .mem_read(rd[0]), .mem_write(wr[0]), .din(di[0]), .is_ready(rdy[0]),
    .is_output_valid(ov[0]), .dout(dout[0]), .mem_stall(stall[0]));

  data_mem_responder #(.MEM_DEPTH(DEPTH), .DELAY(D1)) dut1 (
    .clk(clk), .reset(reset), .is_input_valid(iv[1]), .addr(ad[1]),
    .mem_read(rd[1]), .mem_write(wr[1]), .din(di[1]), .is_ready(rdy[1]),
    .is_output_valid(ov[1]), .dout(dout[1]), .mem_stall(stall[1]));

  always #5 clk = ~clk;

  function automatic int delayOf(input int k);
    return (k == 0) ? D0 : D1;
  endfunction

  function automatic int wordOf(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        pend[k] = 1'b0;
      end else if (pend[k] && cyc == acc[k] + delayOf(k)) begin
        pend[k] = 1'b0;
      end else if (!pend[k] && iv[k] && (rd[k] != wr[k])) begin
        pend[k]  = 1'b1;
        acc[k]   = cyc;
        pRead[k] = rd[k];
        pIdx[k]  = wordOf(ad[k]);
        pData[k] = di[k];
      end
      if (!reset && pend[k] && !pRead[k] && cyc == acc[k] + delayOf(k) - 1) begin
        modelMem[k * DEPTH + pIdx[k]] = pData[k];
      end
    end
    cyc++;
  end

  task automatic checkOutput(input int k);
    logic        eRdy, eOv, eSt;
    logic [31:0] eDout;
    bit          doutKnown;
    eRdy = 1'b1;
    eOv  = 1'b0;
    eSt  = iv[k] && (rd[k] != wr[k]);
    eDout = 32'h0;
    doutKnown = 1'b1;
    if (!reset && pend[k]) begin
      eRdy = 1'b0;
      if (cyc < acc[k] + delayOf(k)) begin
        eSt = 1'b1;
      end else begin
        eSt = 1'b0;
        eOv = 1'b1;
        if (pRead[k]) begin
          if (modelMem.exists(k * DEPTH + pIdx[k])) eDout = modelMem[k * DEPTH + pIdx[k]];
          else doutKnown = 1'b0;
        end
      end
    end
    cmp($sformatf("dut%0d.is_ready@%0d", k, cyc), 32'(rdy[k]), 32'(eRdy));
    cmp($sformatf("dut%0d.is_output_valid@%0d", k, cyc), 32'(ov[k]), 32'(eOv));
    cmp($sformatf("dut%0d.mem_stall@%0d", k, cyc), 32'(stall[k]), 32'(eSt));
    if (doutKnown) cmp($sformatf("dut%0d.dout@%0d", k, cyc), dout[k], eDout);
  endtask

  always @(negedge clk) begin
    if (started) begin
      checkOutput(0);
      checkOutput(1);
    end
  end

  task automatic applyStimulus(input int k, input logic v, input logic r, input logic w,
                               input logic [31:0] a, input logic [31:0] d);
    iv[k] = v;
    rd[k] = r;
    wr[k] = w;
    ad[k] = a;
    di[k] = d;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    applyStimulus(k, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic doReq(input int k, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    applyStimulus(k, 1'b1, r, w, a, d);
    nextCycle();
    idle(k);
    repeat (delayOf(k)) nextCycle();
  endtask

  task automatic readLit(input int k, input logic [31:0] a, input logic [31:0] exp,
                         input string name);
    applyStimulus(k, 1'b1, 1'b1, 1'b0, a, 32'h0);
    nextCycle();
    idle(k);
    repeat (delayOf(k) - 1) nextCycle();
    @(negedge clk);
    cmp({name, " valid"}, 32'(ov[k]), 32'h1);
    cmp({name, " dout"}, dout[k], exp);
    nextCycle();
  endtask

  task automatic checkResetOutputs(input string name);
    for (int k = 0; k < 2; k++) begin
      cmp($sformatf("%s dut%0d is_ready", name, k), 32'(rdy[k]), 32'h1);
      cmp($sformatf("%s dut%0d is_output_valid", name, k), 32'(ov[k]), 32'h0);
      cmp($sformatf("%s dut%0d dout", name, k), dout[k], 32'h0);
      cmp($sformatf("%s dut%0d mem_stall", name, k), 32'(stall[k]), 32'h0);
    end
  endtask

  initial begin
    logic [5:0] expStall;
    logic [5:0] expValid;
    logic [5:0] expReady;
    int pulses;
    expStall = 6'b001111;
    expValid = 6'b010000;
    expReady = 6'b100001;

    idle(0);
    idle(1);
    #1 reset = 1'b1;
    #2;
    checkResetOutputs("por");
    @(posedge clk);
    #1 reset = 1'b0;
    started = 1'b1;

    $display("[TB] write 0xDEADBEEF to 0x100 with cycle-exact timing");
    applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cmp($sformatf("wr100 stall c%0d", i), 32'(stall[0]), 32'(expStall[i]));
      cmp($sformatf("wr100 valid c%0d", i), 32'(ov[0]), 32'(expValid[i]));
      cmp($sformatf("wr100 ready c%0d", i), 32'(rdy[0]), 32'(expReady[i]));
      nextCycle();
      if (i == 0) idle(0);
    end
    readLit(0, 32'h100, 32'hDEADBEEF, "rd100");

    $display("[TB] inputs changing while busy are ignored");
    doReq(0, 1'b0, 1'b1, 32'h200, 32'h55AA55AA);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
    nextCycle();
    idle(0);
    nextCycle();
    applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'h200, 32'h1);
    nextCycle();
    idle(0);
    nextCycle();
    @(negedge clk);
    cmp("busyChange valid", 32'(ov[0]), 32'h1);
    cmp("busyChange dout", dout[0], 32'hDEADBEEF);
    nextCycle();
    readLit(0, 32'h200, 32'h55AA55AA, "rd200");

    $display("[TB] reset in the middle of a write");
    doReq(0, 1'b0, 1'b1, 32'h104, 32'h0);
    applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'h104, 32'h12345678);
    nextCycle();
    idle(0);
    nextCycle();
    #2 reset = 1'b1;
    #1;
    checkResetOutputs("midReset");
    @(posedge clk);
    #1 reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ov[0]) pulses++;
      nextCycle();
    end
    cmp("midReset pulses", 32'(pulses), 32'h0);
    readLit(0, 32'h104, 32'h0, "rd104");

    $display("[TB] illegal and absent requests");
    applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'h100, 32'hFFFFFFFF);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'h100, 32'hFFFFFFFF);
      @(negedge clk);
      cmp($sformatf("illegal ready c%0d", i), 32'(rdy[0]), 32'h1);
      cmp($sformatf("illegal stall c%0d", i), 32'(stall[0]), 32'h0);
      cmp($sformatf("illegal valid c%0d", i), 32'(ov[0]), 32'h0);
      nextCycle();
    end
    idle(0);
    readLit(0, 32'h100, 32'hDEADBEEF, "rd100 after illegal");

    $display("[TB] DELAY=1 instance with address wrap");
    doReq(1, 1'b0, 1'b1, 32'h100, 32'hCAFEF00D);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h100 + 32'(4 * DEPTH), 32'h0);
    @(negedge clk);
    cmp("d1 stall c0", 32'(stall[1]), 32'h1);
    cmp("d1 valid c0", 32'(ov[1]), 32'h0);
    nextCycle();
    idle(1);
    @(negedge clk);
    cmp("d1 valid c1", 32'(ov[1]), 32'h1);
    cmp("d1 dout c1", dout[1], 32'hCAFEF00D);
    cmp("d1 stall c1", 32'(stall[1]), 32'h0);
    nextCycle();
    @(negedge clk);
    cmp("d1 stall c2", 32'(stall[1]), 32'h0);
    cmp("d1 valid c2", 32'(ov[1]), 32'h0);
    cmp("d1 ready c2", 32'(rdy[1]), 32'h1);
    nextCycle();

    repeat (2) nextCycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
